dmem_arbiter: RTL

- Shares the single data-memory port of the memory stage between two requesters: the pipeline MEM stage (CPU port) and the RSA modular-exponentiation accelerator (ACC port).
- Performs at most one memory transaction per cycle and drives the memory's write-enable, address and write-data.
- Returns registered read data to whichever port issued the read.
- Supports locked ACC bursts for operand streaming, with a bounded burst length so the CPU cannot starve.

---
 rtl/dmem_arb_pkg.sv | 10 +
 rtl/dmem_arb_rport.sv | 25 ++
 rtl/dmem_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and default sizes for the data-memory arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {IDLE, LOCK, RELEASE} arb_state_t;
  typedef enum logic {OWN_CPU, OWN_ACC} owner_t;

  localparam int DMEM_WIDTH     = 32;
  localparam int DMEM_BURST_MAX = 16;

endpackage

// File: rtl/dmem_arb_rport.sv
// rtl/dmem_arb_rport.sv - per-port read-return register (one-cycle rvalid, held rdata)
module dmem_arb_rport
  import dmem_arb_pkg::*;
#(
  parameter int WIDTH = DMEM_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             rvalid,
  output logic [WIDTH-1:0] rdata
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= capture;
      if (capture) rdata <= mem_rdata;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/accelerator arbiter for the single data-memory port
// DMEM_ARB_RR_EN: round-robin resolution of IDLE conflicts instead of fixed CPU priority
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WIDTH     = DMEM_WIDTH,
  parameter int BURST_MAX = DMEM_BURST_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic             cpu_gnt,
  output logic             cpu_rvalid,
  output logic [WIDTH-1:0] cpu_rdata,
  input  logic             acc_req,
  input  logic             acc_we,
  input  logic [WIDTH-1:0] acc_addr,
  input  logic [WIDTH-1:0] acc_wdata,
  input  logic             acc_lock,
  output logic             acc_gnt,
  output logic             acc_rvalid,
  output logic [WIDTH-1:0] acc_rdata,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int            CW      = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);

  arb_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

`ifdef DMEM_ARB_RR_EN
  owner_t last_owner, last_owner_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_owner <= OWN_ACC;
    else       last_owner <= last_owner_nxt;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cpu_gnt   = 1'b0;
    acc_gnt   = 1'b0;
`ifdef DMEM_ARB_RR_EN
    last_owner_nxt = last_owner;
`endif
    // Grants are forced low while reset is held, even though they are combinational.
    if (!reset) begin
      case (state)
        IDLE: begin
          if (cpu_req && acc_req) begin
`ifdef DMEM_ARB_RR_EN
            cpu_gnt        = (last_owner == OWN_ACC);
            acc_gnt        = !cpu_gnt;
            last_owner_nxt = cpu_gnt ? OWN_CPU : OWN_ACC;
`else
            cpu_gnt = 1'b1;
`endif
          end else begin
            cpu_gnt = cpu_req;
            acc_gnt = acc_req;
          end
          if (acc_gnt && acc_lock) begin
            cnt_nxt   = CNT_ONE;
            state_nxt = (CNT_ONE == CNT_MAX) ? RELEASE : LOCK;
          end
        end
        LOCK: begin
          acc_gnt = acc_req;
          cpu_gnt = cpu_req && !acc_req;
          if (!acc_lock) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (acc_gnt) begin
            cnt_nxt = cnt + CNT_ONE;
            if (cnt_nxt == CNT_MAX) state_nxt = RELEASE;
          end
        end
        RELEASE: begin
          cpu_gnt   = cpu_req;
          acc_gnt   = acc_req && !cpu_req;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign mem_we    = cpu_gnt ? cpu_we    : (acc_gnt ? acc_we    : 1'b0);
  assign mem_addr  = cpu_gnt ? cpu_addr  : (acc_gnt ? acc_addr  : '0);
  assign mem_wdata = cpu_gnt ? cpu_wdata : (acc_gnt ? acc_wdata : '0);

  dmem_arb_rport #(.WIDTH(WIDTH)) u_cpu_rport (
    .clk       (clk),
    .reset     (reset),
    .capture   (cpu_gnt && !cpu_we),
    .mem_rdata (mem_rdata),
    .rvalid    (cpu_rvalid),
    .rdata     (cpu_rdata)
  );

  dmem_arb_rport #(.WIDTH(WIDTH)) u_acc_rport (
    .clk       (clk),
    .reset     (reset),
    .capture   (acc_gnt && !acc_we),
    .mem_rdata (mem_rdata),
    .rvalid    (acc_rvalid),
    .rdata     (acc_rdata)
  );

endmodule
